// File: rtl/calc_pkg.sv
// Shared encodings, request record and FSM states for the calc port responder.
package calc_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } calc_cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } calc_resp_e;

    // Bit 0 is the MSB on every field, matching the port convention.
    typedef struct packed {
        logic [0:3]  cmd;
        logic [0:31] op1;
        logic [0:31] op2;
    } calc_req_t;

    typedef enum logic {IN_IDLE, IN_OP2} in_state_e;

    typedef enum logic [1:0] {EX_IDLE, EX_SHIFT, EX_RESP} ex_state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/calc_req_fifo.sv
// Request queue: DEPTH entries, wrapping PTR_W-bit pointers plus an occupancy count.
module calc_req_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  calc_req_t push_data,
    input  logic      pop,
    output calc_req_t pop_data,
    output logic      full,
    output logic      empty
);

    calc_req_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign rd_en    = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_port_responder.sv
// Single-port calc responder: two-cycle request capture, request queue, add/sub/shift execute.
// Optional response/error counters when CALC_STATS_EN is defined.
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        out_ovf
`ifdef CALC_STATS_EN
    ,
    output logic [0:15] ok_count,
    output logic [0:15] err_count
`endif
);

    in_state_e   in_state, in_next;
    logic [0:3]  cmd_q;
    logic [0:31] op1_q;
    logic        push;
    calc_req_t   push_data;

    ex_state_e   ex_state, ex_next;
    calc_req_t   head;
    logic        fifo_full, fifo_empty, pop;
    logic [0:31] shift_val, shift_nxt;
    logic [4:0]  shift_cnt;
    logic        shift_left;
    logic        shift_go;
    logic [32:0] sum33;
    logic [0:1]  resp_d;
    logic [0:31] data_d;

    // Input side: command cycle latches cmd/op1, the next cycle supplies op2.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            in_state <= IN_IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
        end else begin
            in_state <= in_next;
            if (in_state == IN_IDLE && req_cmd_in != CMD_NOP) begin
                cmd_q <= req_cmd_in;
                op1_q <= req_data_in;
            end
        end
    end

    always_comb begin
        in_next = in_state;
        push    = 1'b0;
        case (in_state)
            IN_IDLE: if (req_cmd_in != CMD_NOP) in_next = IN_OP2;
            IN_OP2: begin
                push    = 1'b1;
                in_next = IN_IDLE;
            end
            default: in_next = IN_IDLE;
        endcase
    end

    assign push_data = '{cmd: cmd_q, op1: op1_q, op2: req_data_in};

    calc_req_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk       (c_clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sum33     = {1'b0, head.op1} + {1'b0, head.op2};
    assign shift_nxt = shift_left ? (shift_val << 1) : (shift_val >> 1);

    always_comb begin
        ex_next  = ex_state;
        pop      = 1'b0;
        shift_go = 1'b0;
        resp_d   = RESP_ERR;
        data_d   = '0;
        case (ex_state)
            EX_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                ex_next = EX_RESP;
                case (head.cmd)
                    CMD_ADD: if (!sum33[32]) begin
                        resp_d = RESP_OK;
                        data_d = sum33[31:0];
                    end
                    CMD_SUB: if (head.op2 <= head.op1) begin
                        resp_d = RESP_OK;
                        data_d = head.op1 - head.op2;
                    end
                    CMD_SHL, CMD_SHR: begin
                        resp_d = RESP_OK;
                        data_d = head.op1;
                        if (head.op2[27:31] != 5'd0) begin
                            shift_go = 1'b1;
                            ex_next  = EX_SHIFT;
                        end
                    end
                    default: ;
                endcase
            end
            EX_SHIFT: if (shift_cnt == 5'd1) ex_next = EX_RESP;
            EX_RESP:  ex_next = EX_IDLE;
            default:  ex_next = EX_IDLE;
        endcase
    end

    // Outputs are registered so they are valid for exactly the EX_RESP cycle.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            ex_state   <= EX_IDLE;
            shift_val  <= '0;
            shift_cnt  <= '0;
            shift_left <= 1'b0;
            out_resp   <= RESP_NONE;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            ex_state <= ex_next;
            out_resp <= RESP_NONE;
            out_data <= '0;
            out_ovf  <= push && fifo_full && !pop;
            if (shift_go) begin
                shift_val  <= head.op1;
                shift_cnt  <= head.op2[27:31];
                shift_left <= (head.cmd == CMD_SHL);
            end else if (ex_state == EX_SHIFT) begin
                shift_val <= shift_nxt;
                shift_cnt <= shift_cnt - 5'd1;
                if (shift_cnt == 5'd1) begin
                    out_resp <= RESP_OK;
                    out_data <= shift_nxt;
                end
            end else if (pop) begin
                out_resp <= resp_d;
                out_data <= data_d;
            end
        end
    end

`ifdef CALC_STATS_EN
    logic [1:0] ok_inc, err_inc;

    // A drop and an error response can land in the same cycle, hence the 2-bit increment.
    assign ok_inc  = {1'b0, out_resp == RESP_OK};
    assign err_inc = {1'b0, out_resp == RESP_ERR} + {1'b0, out_ovf};

    always_ff @(posedge c_clk) begin
        if (reset) begin
            ok_count  <= '0;
            err_count <= '0;
        end else begin
            ok_count  <= sat_add16(ok_count, ok_inc);
            err_count <= sat_add16(err_count, err_inc);
        end
    end
`endif

endmodule

// File: tb/tb_calc_port_responder.sv
// Randomized bench for calc_port_responder against a timeline model of accepted requests.
module tb_calc_port_responder;

    localparam int DEPTH = 4;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:3]  req_cmd_in = '0;
    logic [0:31] req_data_in = '0;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        out_ovf;
`ifdef CALC_STATS_EN
    logic [0:15] ok_count, err_count;
`endif

    calc_port_responder #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_ovf     (out_ovf)
`ifdef CALC_STATS_EN
        ,
        .ok_count    (ok_count),
        .err_count   (err_count)
`endif
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;
    int ovf_seen = 0;
    int model_drops = 0;

    // Model: per-cycle expected response, keyed by the cycle index it must appear in.
    logic [1:0]  exp_resp [int];
    logic [31:0] exp_data [int];
    bit          exp_ovf  [int];
    int          pop_q [$];
    int          free_at = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Request whose op2 cycle is p: it is queued behind whatever the engine is busy with,
    // popped no earlier than p+1, and answered 1+shamt cycles after the pop.
    task automatic model_accept(input logic [3:0] cmd, input logic [31:0] op1,
                                input logic [31:0] op2, input int p);
        int occ, pop_c, lat, r;
        logic [63:0] s;
        logic [1:0]  rsp;
        logic [31:0] d;
        occ = 0;
        foreach (pop_q[i]) if (pop_q[i] > p) occ++;
        if (occ >= DEPTH) begin
            exp_ovf[p+1] = 1'b1;
            model_drops++;
            return;
        end
        pop_c = (p + 1 > free_at) ? p + 1 : free_at;
        lat = 0;
        rsp = 2'd2;
        d   = 32'd0;
        case (cmd)
            4'd1: begin
                s = 64'(op1) + 64'(op2);
                if (s <= 64'hFFFF_FFFF) begin rsp = 2'd1; d = s[31:0]; end
            end
            4'd2: if (op2 <= op1) begin rsp = 2'd1; d = op1 - op2; end
            4'd5: begin rsp = 2'd1; lat = int'(op2 % 32); d = op1 << lat; end
            4'd6: begin rsp = 2'd1; lat = int'(op2 % 32); d = op1 >> lat; end
            default: ;
        endcase
        r = pop_c + 1 + lat;
        free_at = r + 1;
        pop_q.push_back(pop_c);
        exp_resp[r] = rsp;
        exp_data[r] = d;
    endtask

    always @(negedge c_clk) begin
        if (chk_en) begin
            chk("resp", 32'(out_resp), exp_resp.exists(cyc) ? 32'(exp_resp[cyc]) : 32'd0);
            chk("data", out_data, exp_data.exists(cyc) ? exp_data[cyc] : 32'd0);
            chk("ovf", 32'(out_ovf), exp_ovf.exists(cyc) ? 32'd1 : 32'd0);
            if (out_ovf === 1'b1) ovf_seen++;
        end
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] op1,
                        input logic [31:0] op2, output int t);
        t = cyc;
        req_cmd_in  = cmd;
        req_data_in = op1;
        tick();
        req_cmd_in  = 4'($urandom_range(0, 15));
        req_data_in = op2;
        model_accept(cmd, op1, op2, cyc);
        tick();
        req_cmd_in  = '0;
        req_data_in = $urandom;
    endtask

    task automatic pin(input string nm, input int at, input logic [1:0] r, input logic [31:0] d);
        int g;
        g = 0;
        @(negedge c_clk);
        while (cyc < at && g < 200) begin
            @(negedge c_clk);
            g++;
        end
        if (cyc != at) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_wait cyc=%0d want cyc %0d", nm, cyc, at);
        end else begin
            chk({nm, "_resp"}, 32'(out_resp), 32'(r));
            chk({nm, "_data"}, out_data, d);
            chk({nm, "_model"}, exp_resp.exists(at) ? {exp_resp[at], exp_data[at][29:0]} : 32'hDEAD,
                {r, d[29:0]});
        end
        tick();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (cyc <= free_at + 1 && g < 2000) begin
            tick();
            g++;
        end
        if (g >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout cyc=%0d free_at=%0d", cyc, free_at);
        end
    endtask

    // Reset discards everything in flight, so the model forgets all future expectations.
    task automatic do_reset();
        int ks[$];
        reset = 1'b1;
        req_cmd_in = '0;
        foreach (exp_resp[k]) if (k > cyc) ks.push_back(k);
        foreach (ks[i]) begin
            exp_resp.delete(ks[i]);
            exp_data.delete(ks[i]);
        end
        ks.delete();
        foreach (exp_ovf[k]) if (k > cyc) ks.push_back(k);
        foreach (ks[i]) exp_ovf.delete(ks[i]);
        pop_q.delete();
        free_at = 0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, drops0, r, gap;
        logic [3:0]  c;
        logic [31:0] a, b;

        repeat (3) @(posedge c_clk);
        #1;
        reset = 1'b0;
        @(negedge c_clk);
        chk("rst_resp", 32'(out_resp), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk_en = 1'b1;
        tick();

        send(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, t); pin("add", t + 3, 2'd1, 32'h2000_0000); drain();
        send(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, t); pin("add_ovf", t + 3, 2'd2, 32'h0); drain();
        send(4'd2, 32'h0000_0001, 32'h0000_000F, t); pin("sub_unf", t + 3, 2'd2, 32'h0); drain();
        send(4'd2, 32'h0000_0010, 32'h0000_0010, t); pin("sub_zero", t + 3, 2'd1, 32'h0); drain();
        send(4'd5, 32'h0000_0001, 32'h0000_001F, t); pin("shl31", t + 34, 2'd1, 32'h8000_0000); drain();
        send(4'd6, 32'h8000_0000, 32'h0000_0000, t); pin("shr0", t + 3, 2'd1, 32'h8000_0000); drain();
        send(4'd6, 32'hF000_0000, 32'h0000_0024, t); pin("shr4", t + 7, 2'd1, 32'h0F00_0000); drain();
        send(4'd3, 32'h0000_0001, 32'h0000_0001, t); pin("inv3", t + 3, 2'd2, 32'h0); drain();
        send(4'd4, 32'h0000_0001, 32'h0000_0001, t); pin("inv4", t + 3, 2'd2, 32'h0); drain();

        // Long shift holds the engine while DEPTH+1 adds arrive every 2 cycles.
        ovf_seen = 0;
        drops0 = model_drops;
        send(4'd5, 32'h0000_0001, 32'h0000_001F, t);
        for (int i = 0; i <= DEPTH; i++) send(4'd1, $urandom_range(0, 1000), $urandom_range(0, 1000), t);
        drain();
        chk("stress_ovf_pulses", 32'(ovf_seen), 32'd1);
        chk("stress_model_drops", 32'(model_drops - drops0), 32'd1);

        send(4'd5, 32'h0000_0003, 32'h0000_001F, t);
        send(4'd1, 32'h1, 32'h2, t);
        send(4'd1, 32'h3, 32'h4, t);
        repeat (4) tick();
        do_reset();
        @(negedge c_clk);
        chk("midrst_resp", 32'(out_resp), 32'd0);
        chk("midrst_data", out_data, 32'd0);
        tick();
        send(4'd1, 32'h5, 32'h7, t); pin("post_rst_add", t + 3, 2'd1, 32'h0000_000C);
        repeat (40) tick();

        for (int n = 0; n < 160; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      c = 4'd1;
            else if (r <= 4) c = 4'd2;
            else if (r <= 6) c = 4'd5;
            else if (r == 7) c = 4'd6;
            else if (r == 8) c = 4'($urandom_range(3, 4));
            else             c = 4'($urandom_range(7, 15));
            a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
            b = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
            if (c == 4'd5 || c == 4'd6) b = {$urandom_range(0, 1) ? 27'($urandom) : 27'd0,
                                             5'($urandom_range(0, 12))};
            send(c, a, b, t);
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            if (n == 80) do_reset();
        end
        drain();
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
